// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one barrel_shifter32 among NUM_REQ requesters.
// Define SHIFTER_ARB_ARITH_EN to honour req_arith_i (sign fill on right shifts).

module barrel_shifter32 (
  input  logic [31:0] data_i,
  input  logic [4:0]  amt_i,
  input  logic        dir_i,
  output logic [31:0] data_o
);

  logic [31:0] stage;

  // Logarithmic shifter, logical shifts only; dir_i = 1 shifts right.
  always_comb begin
    stage = data_i;
    for (int b = 0; b < 5; b++) begin
      if (amt_i[b]) begin
        stage = dir_i ? (stage >> (1 << b)) : (stage << (1 << b));
      end
    end
    data_o = stage;
  end

endmodule

module shifter_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_data_i,
  input  logic [NUM_REQ*5-1:0]  req_amt_i,
  input  logic [NUM_REQ-1:0]    req_dir_i,
  input  logic [NUM_REQ-1:0]    req_arith_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_data_o,
  output logic [ID_W-1:0]       resp_id_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {StIdle, StShift, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     op_data_q, op_data_d;
  logic [4:0]      op_amt_q, op_amt_d;
  logic            op_dir_q, op_dir_d;
  logic [31:0]     resp_data_q, resp_data_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   cand_sum;
  logic [ID_W-1:0] cand;
  logic [31:0]     sel_data;
  logic [4:0]      sel_amt;
  logic            accept;
  logic [31:0]     shifter_out;
  logic [31:0]     shift_res;

  // First valid requester at or after ptr_q, wrapping at NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (cand_sum >= (ID_W + 1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (ID_W + 1)'(NUM_REQ);
      end
      cand = cand_sum[ID_W-1:0];
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        sel_data = req_data_i[32*k +: 32];
        sel_amt  = req_amt_i[5*k +: 5];
      end
    end
  end

  assign accept = (state_q == StIdle) && grant_vld && rst_n;

  // rst_n gating keeps req_ready_o low while reset is held with requests pending.
  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  barrel_shifter32 u_shifter (
    .data_i (op_data_q),
    .amt_i  (op_amt_q),
    .dir_i  (op_dir_q),
    .data_o (shifter_out)
  );

`ifdef SHIFTER_ARB_ARITH_EN
  logic op_arith_q, op_arith_d;
  logic fill_en;

  always_comb begin
    op_arith_d = op_arith_q;
    if (accept) begin
      op_arith_d = req_arith_i[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_arith_q <= 1'b0;
    end else begin
      op_arith_q <= op_arith_d;
    end
  end

  // Left shifts never sign-fill, regardless of the arith flag.
  assign fill_en   = op_dir_q & op_arith_q & op_data_q[31];
  assign shift_res = shifter_out | (fill_en ? ~(32'hFFFF_FFFF >> op_amt_q) : 32'h0);
`else
  logic unused_arith;
  assign unused_arith = ^req_arith_i;
  assign shift_res    = shifter_out;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_data_d   = op_data_q;
    op_amt_d    = op_amt_q;
    op_dir_d    = op_dir_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_data_d = sel_data;
          op_amt_d  = sel_amt;
          op_dir_d  = req_dir_i[grant_idx];
          id_d      = grant_idx;
          ptr_d     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d   = StShift;
        end
      end
      StShift: begin
        resp_data_d = shift_res;
        state_d     = StResp;
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      op_data_q   <= '0;
      op_amt_q    <= '0;
      op_dir_q    <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_data_q   <= op_data_d;
      op_amt_q    <= op_amt_d;
      op_dir_q    <= op_dir_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign resp_valid_o = (state_q == StResp);
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = id_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed self-checking bench for shifter_arbiter (NUM_REQ = 2).

module tb_shifter_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_data;
  logic [9:0]  req_amt;
  logic [1:0]  req_dir;
  logic [1:0]  req_arith;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_id;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  shifter_arbiter #(
    .NUM_REQ (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_i   (req_data),
    .req_amt_i    (req_amt),
    .req_dir_i    (req_dir),
    .req_arith_i  (req_arith),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_id_o    (resp_id),
    .busy_o       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] a,
                         input logic dir, input logic ar);
    req_data[32*i +: 32] = d;
    req_amt[5*i +: 5]    = a;
    req_dir[i]           = dir;
    req_arith[i]         = ar;
  endtask

  // Entered and left on a falling edge; resp_ready must be 1.
  task automatic single_op(input string tag, input int i, input logic [31:0] d,
                           input logic [4:0] a, input logic dir, input logic ar,
                           input logic [31:0] exp);
    set_req(i, d, a, dir, ar);
    req_valid = 2'b01 << i;
    #1;
    check_eq({tag, "_ready"}, 32'(req_ready), 32'h1 << i);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_eq({tag, "_shift_busy"}, 32'(busy), 32'h1);
    check_eq({tag, "_shift_rv"}, 32'(resp_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_rv"}, 32'(resp_valid), 32'h1);
    check_eq({tag, "_data"}, resp_data, exp);
    check_eq({tag, "_id"}, 32'(resp_id), 32'(i));
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_done_rv"}, 32'(resp_valid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 2'b11;
    req_data   = '0;
    req_amt    = '0;
    req_dir    = '0;
    req_arith  = '0;
    #12;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_rv", 32'(resp_valid), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_data", resp_data, 32'h0);
    check_eq("rst_id", 32'(resp_id), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);

    single_op("left4", 0, 32'h0000_00F1, 5'd4, 1'b0, 1'b0, 32'h0000_0F10);
    single_op("lsr28", 1, 32'hF000_0000, 5'd28, 1'b1, 1'b0, 32'h0000_000F);
    single_op("left31", 0, 32'h0000_0003, 5'd31, 1'b0, 1'b1, 32'h8000_0000);
`ifdef SHIFTER_ARB_ARITH_EN
    single_op("asr4", 1, 32'h8000_0010, 5'd4, 1'b1, 1'b1, 32'hF800_0001);
`else
    single_op("asr4", 1, 32'h8000_0010, 5'd4, 1'b1, 1'b1, 32'h0800_0001);
`endif
    single_op("asr0", 1, 32'h8000_0010, 5'd0, 1'b1, 1'b1, 32'h8000_0010);

    // Round-robin with both requesters continuously valid; ptr is 0 here.
    set_req(0, 32'h0000_0001, 5'd1, 1'b0, 1'b0);
    set_req(1, 32'h0000_0100, 5'd4, 1'b1, 1'b0);
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      #1;
      check_eq("rr_grant", 32'(req_ready), 32'h1 << (n % 2));
      @(posedge clk);
      @(negedge clk);
      check_eq("rr_shift_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);
      check_eq("rr_rv", 32'(resp_valid), 32'h1);
      check_eq("rr_id", 32'(resp_id), 32'(n % 2));
      check_eq("rr_data", resp_data, (n % 2 == 0) ? 32'h0000_0002 : 32'h0000_0010);
      check_eq("rr_resp_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 2'b00;

    // Backpressure: five stalled RESP cycles with both requesters pending.
    set_req(0, 32'h0000_00A5, 5'd8, 1'b0, 1'b0);
    req_valid = 2'b01;
    #1;
    check_eq("bp_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid  = 2'b11;
    resp_ready = 1'b0;
    @(posedge clk);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check_eq("bp_rv", 32'(resp_valid), 32'h1);
      check_eq("bp_data", resp_data, 32'h0000_A500);
      check_eq("bp_id", 32'(resp_id), 32'h0);
      check_eq("bp_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_done_rv", 32'(resp_valid), 32'h0);
    check_eq("bp_next_grant", 32'(req_ready), 32'h2);
    req_valid = 2'b00;

    // Reset during SHIFT: result is lost, ptr returns to 0.
    set_req(0, 32'h0000_0001, 5'd3, 1'b0, 1'b0);
    req_valid = 2'b01;
    #1;
    check_eq("mr_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    #1;
    check_eq("mr_busy", 32'(busy), 32'h0);
    check_eq("mr_rv", 32'(resp_valid), 32'h0);
    check_eq("mr_data", resp_data, 32'h0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_eq("mr_hold_rv", 32'(resp_valid), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mr_post_rv", 32'(resp_valid), 32'h0);
    check_eq("mr_post_busy", 32'(busy), 32'h0);
    set_req(1, 32'h0000_0040, 5'd2, 1'b1, 1'b0);
    req_valid = 2'b11;
    #1;
    check_eq("mr_ptr0_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check_eq("mr_new_rv", 32'(resp_valid), 32'h1);
    check_eq("mr_new_id", 32'(resp_id), 32'h0);
    check_eq("mr_new_data", resp_data, 32'h0000_0008);
    @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shifter_arbiter.md
# shifter_arbiter

Round-robin arbiter and sequencer that shares one `barrel_shifter32` instance among `NUM_REQ` requesters (e.g. the EX-stage ALU shift path and the multi-cycle unit).
- Each requester presents an operand, a shift amount, a direction and an arithmetic flag over a valid/ready handshake.
- The block grants one requester, latches its operands, drives the shifter, registers the result and returns it with the requester ID over a second valid/ready handshake.
- Arithmetic right-shift sign fill is applied here, because `barrel_shifter32` performs logical shifts only.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 2–8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester ID.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester grant/accept.
- `req_data`  in  NUM_REQ*32  operand; requester i uses slice [32*i +: 32].
- `req_amt`  in  NUM_REQ*5  shift amount, slice [5*i +: 5].
- `req_dir`  in  NUM_REQ  0 = left, 1 = right.
- `req_arith`  in  NUM_REQ  1 = arithmetic right shift (see Configuration).
- `resp_valid`  out  1  result valid.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_data`  out  32  shifted result.
- `resp_id`  out  ID_W  index of the requester that owns `resp_data`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
State machine with states IDLE, SHIFT and RESP.
- **IDLE:** the round-robin pointer `ptr` selects the first i ≥ `ptr` (wrapping) with `req_valid[i]`=1.
  - `req_ready[i]`=1 for that i only; the output is combinational from `req_valid` and `ptr`.
  - On handshake: latch data, amount, direction, arith and ID; set `ptr` = (i+1) mod NUM_REQ; go to SHIFT.
  - With no valid requests: stay in IDLE, all `req_ready`=0, `ptr` unchanged.
- **SHIFT:** the latched operands drive `barrel_shifter32`.
  - The result, including the arithmetic fill when enabled, is registered into `resp_data`.
  - Go to RESP.
- **RESP:** `resp_valid`=1; `resp_data` and `resp_id` are held stable.
  - On `resp_valid && resp_ready`, go to IDLE.
  - No new request is accepted in RESP.
- `req_ready` is 0 in SHIFT and RESP.
- Requesters must hold their inputs stable while `req_valid`=1 and `req_ready`=0.
- Arithmetic fill, when enabled, is valid and sign=1: `resp_data` = (data >> amt) | ~(32'hFFFFFFFF >> amt).
  - amt = 0 returns the operand unchanged.
  - An amount is never ≥ 32; the 5-bit port wraps by construction.
- The arith flag is ignored when direction = left.

## Timing
- Reset values:
  - state = IDLE, `ptr` = 0.
  - `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0.
  - `busy` = 0; `req_ready` = 0 while `rst_n` = 0.
- Latency: accept in cycle N, SHIFT in N+1, `resp_valid`=1 from N+2.
- Best-case throughput is one operation per 3 cycles, with `resp_ready` held at 1.
- A stalled `resp_ready` holds RESP indefinitely; there is no timeout.
- Simultaneous requests are resolved strictly by `ptr`; the granted requester becomes lowest priority next time.
- A request is never dropped once granted.
- `rst_n` falling mid-operation (SHIFT or RESP):
  - all state and outputs return to reset values immediately; the in-flight result is lost.
  - Operation resumes from IDLE on the first rising edge after `rst_n` rises.

## Configuration
- Macro `SHIFTER_ARB_ARITH_EN`.
- **Defined:** `req_arith` is honoured for right shifts and sign fill is applied as in Operation.
- **Undefined:** `req_arith` is ignored, all right shifts are logical, and the fill logic is not synthesized.

## Test plan
- Reset: `rst_n`=0 with all `req_valid`=1 -> all `req_ready`=0, `resp_valid`=0, `busy`=0.
- Single left shift: req0 data=0x0000_00F1, amt=4, dir=0 -> `resp_valid` at N+2, `resp_data`=0x0000_0F10, `resp_id`=0.
- Arithmetic right shift (macro on): req1 data=0x8000_0010, amt=4, dir=1, arith=1 -> 0xF800_0001.
  - Same stimulus with the macro off -> 0x0800_0001.
  - Same stimulus with amt=0 -> 0x8000_0010.
- Round-robin: req0 and req1 both held valid for 4 operations -> grants in order 0,1,0,1, and `resp_id` follows the same order.
- Backpressure: `resp_ready`=0 for 5 cycles -> `resp_data`/`resp_id` stable, `req_ready`=0 throughout; the operation completes on the first `resp_ready`=1.
- Reset mid-op: assert `rst_n`=0 in SHIFT -> `resp_valid` never rises for that request; after release, the next grant goes to requester 0 (`ptr`=0).
